// File: rtl/term_ctrl.sv
// Terminal byte-stream controller: decodes printable, control and ESC Y row/col bytes
// into registered cursor/char write strobes for a downstream display stage.
module term_ctrl #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30
) (
  input  logic       CLK_I,
  input  logic       RST_N,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [4:0] currow,
  input  logic [6:0] curcol,
  output logic [7:0] data,
  output logic       dstrobe,
  output logic [1:0] dtype,
  output logic       busy
);

  localparam logic [7:0]  LastCol   = 8'(COLS - 1);
  localparam logic [7:0]  LastRow   = 8'(ROWS - 1);
  localparam logic [11:0] FillCount = 12'(ROWS * COLS);

  localparam logic [1:0] TypeChar = 2'd0;
  localparam logic [1:0] TypeCol  = 2'd1;
  localparam logic [1:0] TypeRow  = 2'd2;

  typedef enum logic [3:0] {
    StIdle, StGap, StEsc, StEscRow, StEscCol, StBsRow,
    StClrHc, StClrHr, StClrFill, StClrEc, StClrEr
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [11:0] r_cnt, w_cnt_nxt;
  logic [4:0]  r_row, w_row_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_strobe, w_strobe_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic [1:0]  r_dtype, w_dtype_nxt;

  logic       w_accept;
  logic       w_below;
  logic [7:0] w_off;
  logic [7:0] w_col_arg;
  logic [4:0] w_row_arg;
  logic [7:0] w_tab_raw;
  logic [7:0] w_tab;
  logic [7:0] w_lf;

  assign w_accept  = rx_valid && r_ready;
  assign w_below   = (rx_data < 8'h20);
  assign w_off     = rx_data - 8'h20;
  assign w_col_arg = w_below ? 8'd0 : ((w_off > LastCol) ? LastCol : w_off);
  assign w_row_arg = w_below ? 5'd0 : ((w_off > LastRow) ? LastRow[4:0] : w_off[4:0]);
  assign w_tab_raw = ({1'b0, curcol} | 8'h07) + 8'h01;
  assign w_tab     = (w_tab_raw > LastCol) ? LastCol : w_tab_raw;
  assign w_lf      = ({3'b000, currow} == LastRow) ? 8'd0 : ({3'b000, currow} + 8'd1);

  // Outputs are registered alongside the state, so a strobe appears the cycle after
  // its decision; GAP holds one extra cycle when entered with a strobe in flight.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_row_nxt    = r_row;
    w_strobe_nxt = 1'b0;
    w_data_nxt   = 8'h00;
    w_dtype_nxt  = TypeChar;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (rx_data == 8'h1B) begin
            w_state_nxt = StEsc;
          end else if (rx_data == 8'h0C) begin
            w_state_nxt  = StClrHc;
            w_strobe_nxt = 1'b1;
            w_dtype_nxt  = TypeCol;
          end else if (rx_data == 8'h0D) begin
            w_state_nxt  = StGap;
            w_strobe_nxt = 1'b1;
            w_dtype_nxt  = TypeCol;
          end else if (rx_data == 8'h0A) begin
            w_state_nxt  = StGap;
            w_strobe_nxt = 1'b1;
            w_dtype_nxt  = TypeRow;
            w_data_nxt   = w_lf;
          end else if (rx_data == 8'h09) begin
            w_state_nxt  = StGap;
            w_strobe_nxt = 1'b1;
            w_dtype_nxt  = TypeCol;
            w_data_nxt   = w_tab;
          end else if (rx_data == 8'h08) begin
            w_state_nxt = StGap;
            if (curcol != 7'd0) begin
              w_strobe_nxt = 1'b1;
              w_dtype_nxt  = TypeCol;
              w_data_nxt   = {1'b0, curcol - 7'd1};
            end else if (currow != 5'd0) begin
              w_state_nxt  = StBsRow;
              w_strobe_nxt = 1'b1;
              w_dtype_nxt  = TypeCol;
              w_data_nxt   = LastCol;
              w_row_nxt    = currow - 5'd1;
            end
          end else if (!w_below && rx_data != 8'h7F) begin
            w_state_nxt  = StGap;
            w_strobe_nxt = 1'b1;
            w_data_nxt   = rx_data;
          end
        end
      end
      StGap: begin
        if (!r_strobe) w_state_nxt = StIdle;
      end
      StEsc: begin
        if (w_accept) w_state_nxt = (rx_data == 8'h59) ? StEscRow : StIdle;
      end
      StEscRow: begin
        if (w_accept) begin
          w_row_nxt   = w_row_arg;
          w_state_nxt = StEscCol;
        end
      end
      StEscCol: begin
        if (w_accept) begin
          w_state_nxt  = StBsRow;
          w_strobe_nxt = 1'b1;
          w_dtype_nxt  = TypeCol;
          w_data_nxt   = w_col_arg;
        end
      end
      // Shared second half of BS-wrap and ESC Y: emit the latched row.
      StBsRow: begin
        w_state_nxt  = StGap;
        w_strobe_nxt = 1'b1;
        w_dtype_nxt  = TypeRow;
        w_data_nxt   = {3'b000, r_row};
      end
      StClrHc: begin
        w_state_nxt  = StClrHr;
        w_strobe_nxt = 1'b1;
        w_dtype_nxt  = TypeRow;
      end
      StClrHr: begin
        w_state_nxt  = StClrFill;
        w_strobe_nxt = 1'b1;
        w_data_nxt   = 8'h20;
        w_cnt_nxt    = 12'd1;
      end
      StClrFill: begin
        w_strobe_nxt = 1'b1;
        if (r_cnt == FillCount) begin
          w_state_nxt = StClrEc;
          w_dtype_nxt = TypeCol;
          w_cnt_nxt   = 12'd0;
        end else begin
          w_data_nxt = 8'h20;
          w_cnt_nxt  = r_cnt + 12'd1;
        end
      end
      StClrEc: begin
        w_state_nxt  = StClrEr;
        w_strobe_nxt = 1'b1;
        w_dtype_nxt  = TypeRow;
      end
      StClrEr: w_state_nxt = StGap;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_ready_nxt = (w_state_nxt inside {StIdle, StEsc, StEscRow, StEscCol});

  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= StIdle;
      r_cnt    <= 12'd0;
      r_row    <= 5'd0;
      r_ready  <= 1'b0;
      r_strobe <= 1'b0;
      r_data   <= 8'h00;
      r_dtype  <= TypeChar;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_row    <= w_row_nxt;
      r_ready  <= w_ready_nxt;
      r_strobe <= w_strobe_nxt;
      r_data   <= w_data_nxt;
      r_dtype  <= w_dtype_nxt;
    end
  end

  assign rx_ready = r_ready;
  assign dstrobe  = r_strobe;
  assign data     = r_data;
  assign dtype    = r_dtype;
  assign busy     = !(r_state inside {StIdle, StEsc, StEscRow, StEscCol});

endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: directed vector table, clear-screen and reset sequences,
// and random bytes checked against a byte-level model of the command stream.
module tb_term_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk;
  logic       RST_N;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [4:0] currow;
  logic [6:0] curcol;
  logic [7:0] data;
  logic       dstrobe;
  logic [1:0] dtype;
  logic       busy;

  term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLK_I   (clk),
    .RST_N   (RST_N),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .currow  (currow),
    .curcol  (curcol),
    .data    (data),
    .dstrobe (dstrobe),
    .dtype   (dtype),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed strobes: {cycle, busy, dtype, data}
  logic [42:0] mon_q[$];
  logic [9:0]  exp_q[$];
  int unsigned cyc = 0;

  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (dstrobe) mon_q.push_back({cyc, busy, dtype, data});

  typedef struct {
    logic [7:0] b;
    int         row;
    int         col;
    int         n;
    logic [9:0] s0;
    logic [9:0] s1;
  } vec_t;

  vec_t vt[27];

  int md = 0;  // model parser: 0 normal, 1 after ESC, 2 want row, 3 want col
  int mr = 0;

  task automatic check(input bit ok, input string nm, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic wait_ready(input int lim);
    for (int k = 0; k < lim; k++) begin
      if (rx_ready) break;
      @(negedge clk);
    end
    if (!rx_ready) check(1'b0, "ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] b, input int row, input int col);
    wait_ready(3000);
    rx_data  = b;
    rx_valid = 1'b1;
    currow   = 5'(row);
    curcol   = 7'(col);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic settle();
    wait_ready(3000);
    @(negedge clk);
    #1;
  endtask

  task automatic check_stream(input string nm);
    logic [42:0] e;
    logic [9:0]  fg, fe;
    bit ok;
    ok = (mon_q.size() == exp_q.size());
    if (ok) begin
      foreach (exp_q[i]) begin
        e = mon_q[i];
        if (e[9:0] != exp_q[i]) ok = 1'b0;
      end
    end
    fg = '0;
    fe = '0;
    if (mon_q.size() > 0) begin
      e  = mon_q[0];
      fg = e[9:0];
    end
    if (exp_q.size() > 0) fe = exp_q[0];
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d strobes first=%h, expected %0d strobes first=%h",
               nm, mon_q.size(), fg, exp_q.size(), fe);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  function automatic void push(input int t, input int d);
    exp_q.push_back({t[1:0], d[7:0]});
  endfunction

  function automatic int clamp_arg(input logic [7:0] b, input int lim);
    int v;
    v = (b < 8'h20) ? 0 : int'(b) - 32;
    return (v > lim) ? lim : v;
  endfunction

  // Behavioural model: expected (dtype, data) list for one accepted byte.
  function automatic void model_byte(input logic [7:0] b, input int row, input int col);
    int v;
    case (md)
      1: md = (b == 8'h59) ? 2 : 0;
      2: begin
        mr = clamp_arg(b, ROWS - 1);
        md = 3;
      end
      3: begin
        push(1, clamp_arg(b, COLS - 1));
        push(2, mr);
        md = 0;
      end
      default: begin
        if (b == 8'h1B) md = 1;
        else if (b == 8'h0D) push(1, 0);
        else if (b == 8'h0A) push(2, (row == ROWS - 1) ? 0 : row + 1);
        else if (b == 8'h09) begin
          v = (col | 7) + 1;
          push(1, (v > COLS - 1) ? COLS - 1 : v);
        end else if (b == 8'h08) begin
          if (col > 0) push(1, col - 1);
          else if (row > 0) begin
            push(1, COLS - 1);
            push(2, row - 1);
          end
        end else if (b >= 8'h20 && b != 8'h7F) push(0, int'(b));
      end
    endcase
  endfunction

  initial begin
    logic [42:0] e;
    int n, fills, busy_bad, gaps;
    int unsigned prev;
    logic [9:0] h0, h1, t0, t1;

    RST_N    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    currow   = 5'd0;
    curcol   = 7'd0;

    vt[0]  = '{8'h41, 0, 0, 1, 10'h041, 10'h000};
    vt[1]  = '{8'h0D, 5, 20, 1, 10'h100, 10'h000};
    vt[2]  = '{8'h0A, 29, 10, 1, 10'h200, 10'h000};
    vt[3]  = '{8'h0A, 3, 10, 1, 10'h204, 10'h000};
    vt[4]  = '{8'h09, 0, 5, 1, 10'h108, 10'h000};
    vt[5]  = '{8'h09, 0, 77, 1, 10'h14F, 10'h000};
    vt[6]  = '{8'h08, 3, 0, 2, 10'h14F, 10'h202};
    vt[7]  = '{8'h08, 0, 0, 0, 10'h000, 10'h000};
    vt[8]  = '{8'h08, 7, 4, 1, 10'h103, 10'h000};
    vt[9]  = '{8'h7F, 0, 0, 0, 10'h000, 10'h000};
    vt[10] = '{8'h00, 0, 0, 0, 10'h000, 10'h000};
    vt[11] = '{8'h80, 0, 0, 1, 10'h080, 10'h000};
    vt[12] = '{8'h1B, 0, 0, 0, 10'h000, 10'h000};
    vt[13] = '{8'h59, 0, 0, 0, 10'h000, 10'h000};
    vt[14] = '{8'h25, 0, 0, 0, 10'h000, 10'h000};
    vt[15] = '{8'h3A, 0, 0, 2, 10'h11A, 10'h205};
    vt[16] = '{8'h1B, 0, 0, 0, 10'h000, 10'h000};
    vt[17] = '{8'h59, 0, 0, 0, 10'h000, 10'h000};
    vt[18] = '{8'h7F, 0, 0, 0, 10'h000, 10'h000};
    vt[19] = '{8'h7F, 0, 0, 2, 10'h14F, 10'h21D};
    vt[20] = '{8'h1B, 0, 0, 0, 10'h000, 10'h000};
    vt[21] = '{8'h41, 0, 0, 0, 10'h000, 10'h000};
    vt[22] = '{8'h41, 0, 0, 1, 10'h041, 10'h000};
    vt[23] = '{8'h1B, 0, 0, 0, 10'h000, 10'h000};
    vt[24] = '{8'h59, 0, 0, 0, 10'h000, 10'h000};
    vt[25] = '{8'h10, 0, 0, 0, 10'h000, 10'h000};
    vt[26] = '{8'h05, 0, 0, 2, 10'h100, 10'h200};

    // Reset state and release
    repeat (3) @(negedge clk);
    check(dstrobe == 0 && data == 0 && dtype == 0 && rx_ready == 0 && busy == 0,
          "reset_outputs", {dstrobe, dtype, data, rx_ready, busy}, 0);
    RST_N = 1'b1;
    @(posedge clk);
    #1 check(rx_ready == 1'b1, "ready_after_reset", rx_ready, 1);

    // Single char timing
    wait_ready(100);
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    check(dstrobe && dtype == 2'd0 && data == 8'h41, "char_strobe_n1",
          {dstrobe, dtype, data}, {1'b1, 2'd0, 8'h41});
    check(!rx_ready && busy, "char_ready_busy_n1", {rx_ready, busy}, 1);
    @(negedge clk);
    check(!rx_ready && !dstrobe, "char_gap_n2", {rx_ready, dstrobe}, 0);
    @(negedge clk);
    check(rx_ready, "char_ready_n3", rx_ready, 1);
    #1 mon_q.delete();

    // Directed vector table
    foreach (vt[i]) begin
      send(vt[i].b, vt[i].row, vt[i].col);
      settle();
      if (vt[i].n > 0) exp_q.push_back(vt[i].s0);
      if (vt[i].n > 1) exp_q.push_back(vt[i].s1);
      check_stream($sformatf("vec%0d_byte%h", i, vt[i].b));
    end

    // Full clear-screen sequence
    send(8'h0C, 12, 40);
    settle();
    n = mon_q.size();
    check(n == ROWS * COLS + 4, "ff_strobe_count", n, ROWS * COLS + 4);
    fills = 0;
    busy_bad = 0;
    gaps = 0;
    prev = 0;
    foreach (mon_q[i]) begin
      e = mon_q[i];
      if (i >= 2 && i < n - 2 && e[9:0] == 10'h020) fills++;
      if (!e[10]) busy_bad++;
      if (i > 0 && e[42:11] != prev + 1) gaps++;
      prev = e[42:11];
    end
    check(fills == ROWS * COLS, "ff_fill_count", fills, ROWS * COLS);
    check(busy_bad == 0, "ff_busy_low", busy_bad, 0);
    check(gaps == 0, "ff_strobe_gaps", gaps, 0);
    h0 = '1; h1 = '1; t0 = '1; t1 = '1;
    if (n >= 4) begin
      e = mon_q[0];     h0 = e[9:0];
      e = mon_q[1];     h1 = e[9:0];
      e = mon_q[n - 2]; t0 = e[9:0];
      e = mon_q[n - 1]; t1 = e[9:0];
    end
    check(h0 == 10'h100 && h1 == 10'h200, "ff_home", {h0, h1}, {10'h100, 10'h200});
    check(t0 == 10'h100 && t1 == 10'h200, "ff_end_home", {t0, t1}, {10'h100, 10'h200});
    mon_q.delete();

    // Random bytes against the model
    for (int it = 0; it < 400; it++) begin
      logic [7:0] b;
      int row, col, k;
      row = $urandom_range(0, ROWS - 1);
      col = $urandom_range(0, COLS - 1);
      if ($urandom_range(0, 3) == 0) col = 0;
      if ($urandom_range(0, 5) == 0) row = ($urandom_range(0, 1) == 1) ? 0 : ROWS - 1;
      if (md == 1) b = ($urandom_range(0, 3) != 0) ? 8'h59 : 8'($urandom_range(0, 255));
      else if (md >= 2) b = 8'($urandom_range(0, 255));
      else begin
        k = $urandom_range(0, 9);
        case (k)
          0, 1, 2: b = 8'($urandom_range(32, 255));
          3:       b = 8'h0D;
          4:       b = 8'h0A;
          5:       b = 8'h09;
          6, 7:    b = 8'h08;
          8:       b = 8'h1B;
          default: b = 8'($urandom_range(0, 31));
        endcase
        if (b == 8'h0C) b = 8'h7F;
      end
      model_byte(b, row, col);
      send(b, row, col);
      settle();
      check_stream($sformatf("rand%0d_byte%h_r%0d_c%0d", it, b, row, col));
    end
    for (int it = 0; it < 3 && md != 0; it++) begin
      model_byte(8'h41, 0, 0);
      send(8'h41, 0, 0);
      settle();
      check_stream("rand_drain");
    end

    // Reset during the fill
    send(8'h0C, 0, 0);
    for (int k = 0; k < 1500 && mon_q.size() < 1002; k++) @(negedge clk);
    #2 RST_N = 1'b0;
    #1 check(!dstrobe && !busy && !rx_ready, "midfill_reset_outputs",
             {dstrobe, busy, rx_ready}, 0);
    repeat (2) @(negedge clk);
    mon_q.delete();
    RST_N = 1'b1;
    @(posedge clk);
    #1 check(rx_ready && !busy, "midfill_ready_after_release", {rx_ready, busy}, 2);
    repeat (20) @(negedge clk);
    #1 check(mon_q.size() == 0, "midfill_no_residual", mon_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
